// File: rtl/inst_fetch_if.sv
// Instruction fetch bus bundle: memory request/response, redirect and decoder hand-off.
// The fetch stage is the master; memory, branch unit and decoder sit on the slave side.
interface inst_fetch_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_ready;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            flush_pipe;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, flush_pipe,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, flush_pipe,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               dec_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, issues credit-limited fetches and buffers {inst, pc} for decode.
// Redirects flush the buffer and mark every outstanding response as stale.
module inst_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, FETCH} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            flush_q, flush_d;

    logic [XLEN-1:0] inst_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];

    logic            in_fetch;
    logic [CW:0]     credit_used;
    logic            req_valid;
    logic            fire;
    logic            rsp;
    logic            redir;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redir_pc;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rsp_pc_d    = rsp_pc_q;
        inflight_d  = inflight_q;
        drop_d      = drop_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        flush_d     = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;

        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            default: state_d = IDLE;
        endcase

        in_fetch    = (state_q == FETCH);
        credit_used = {1'b0, inflight_q} + {1'b0, count_q};
        req_valid   = in_fetch && (credit_used < (CW + 1)'(DEPTH));
        fire        = req_valid && bus.imem_req_ready;
        rsp         = in_fetch && bus.imem_rsp_valid;
        redir       = in_fetch && bus.redirect_valid;
        redir_pc    = bus.redirect_pc & ~XLEN'(3);

        inflight_d = inflight_q + CW'(fire) - CW'(rsp);
        if (fire) begin
            pc_d = pc_q + XLEN'(4);
        end

        if (redir) begin
            // Everything still outstanding after this edge (including a request fired now)
            // belongs to the old stream, so drop equals the updated inflight count.
            pc_d     = redir_pc;
            rsp_pc_d = redir_pc;
            drop_d   = inflight_q + CW'(fire) - CW'(rsp);
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            flush_d  = 1'b1;
        end else begin
            if (rsp) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push = 1'b1;
                end
            end
            pop = bus.dec_ready && (count_q != '0);
            if (push) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            flush_q    <= flush_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= bus.imem_rsp_data;
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = (count_q != '0);
    assign bus.inst           = (count_q != '0) ? inst_mem_q[rd_ptr_q] : '0;
    assign bus.inst_pc        = (count_q != '0) ? pc_mem_q[rd_ptr_q] : '0;
    assign bus.flush_pipe     = flush_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed phases plus random traffic against a request-tagging
// memory/decoder reference model; outputs checked every cycle on the falling edge.
module tb_inst_fetch;
    localparam int unsigned     XLEN     = 32;
    localparam int unsigned     DEPTH    = 2;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst;

    inst_fetch_if #(.XLEN(XLEN)) bus ();

    inst_fetch #(
        .XLEN    (XLEN),
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    // Reference: outstanding memory requests tagged stale on redirect, and the decoder queue.
    req_t        outst[$];
    ent_t        fifo[$];
    logic [31:0] m_pc;
    bit          m_fetch;
    bit          m_flush;
    int unsigned cyc;
    int unsigned lat_min, lat_max;
    int unsigned k_ready, k_dec, k_redir;
    int unsigned n_cmp, n_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit pct(input int unsigned p);
        return ($urandom_range(99, 0) < p);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit rst_v, input bit ready_v, input bit dec_v,
                        input bit redir_v, input logic [31:0] rpc);
        bit          exp_rv, fire, rv, redir;
        logic [31:0] old_pc;
        req_t        r;
        ent_t        e;
        int unsigned due;

        exp_rv = m_fetch && ((outst.size() + fifo.size()) < DEPTH);
        chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_rv});
        chk("req_addr", bus.imem_req_addr, m_pc);
        chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, fifo.size() != 0});
        chk("inst", bus.inst, (fifo.size() != 0) ? fifo[0].data : 32'h0);
        chk("inst_pc", bus.inst_pc, (fifo.size() != 0) ? fifo[0].pc : 32'h0);
        chk("flush_pipe", {31'b0, bus.flush_pipe}, {31'b0, m_flush});

        rv = rst_v && (outst.size() != 0) && (outst[0].due <= cyc + 1);

        rst                = rst_v;
        bus.imem_req_ready = ready_v;
        bus.dec_ready      = dec_v;
        bus.redirect_valid = redir_v;
        bus.redirect_pc    = rpc;
        bus.imem_rsp_valid = rst_v ? rv : 1'($urandom_range(1, 0));
        bus.imem_rsp_data  = rv ? mem_word(outst[0].addr) : $urandom;

        if (!rst_v) begin
            outst.delete();
            fifo.delete();
            m_pc    = RESET_PC;
            m_fetch = 1'b0;
            m_flush = 1'b0;
        end else begin
            fire   = exp_rv && ready_v;
            old_pc = m_pc;
            redir  = m_fetch && redir_v;
            if (rv) r = outst.pop_front();
            if (redir) begin
                fifo.delete();
                foreach (outst[i]) outst[i].stale = 1'b1;
                m_pc    = rpc & ~32'h3;
                m_flush = 1'b1;
            end else begin
                m_flush = 1'b0;
                if (dec_v && fifo.size() != 0) void'(fifo.pop_front());
                if (rv && !r.stale) begin
                    e.pc   = r.addr;
                    e.data = mem_word(r.addr);
                    fifo.push_back(e);
                end
                if (fire) m_pc = old_pc + 32'h4;
            end
            if (fire) begin
                due = cyc + 1 + $urandom_range(lat_max, lat_min);
                if (outst.size() != 0 && outst[$].due > due) due = outst[$].due;
                r.addr  = old_pc;
                r.due   = due;
                r.stale = redir;
                outst.push_back(r);
            end
            m_fetch = 1'b1;
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            step(1'b1, pct(k_ready), pct(k_dec), pct(k_redir), $urandom);
        end
    endtask

    task automatic do_reset(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            step(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)), $urandom);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        outst.delete();
        fifo.delete();
        m_pc    = RESET_PC;
        m_fetch = 1'b0;
        m_flush = 1'b0;

        rst                = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.dec_ready      = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);

        // boot: 1-cycle memory, decoder always ready
        lat_min = 1; lat_max = 1;
        k_ready = 100; k_dec = 100; k_redir = 0;
        do_reset(3);
        run(12);

        // backpressure from boot, then drain, then a 5-cycle memory stall
        do_reset(2);
        k_dec = 0;
        run(8);
        k_dec = 100;
        run(4);
        k_ready = 0;
        run(5);
        k_ready = 100;
        run(6);

        // redirect with two in flight on a 3-cycle memory
        lat_min = 3; lat_max = 3;
        run(6);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        run(10);

        // redirect coinciding with a response and a fired request; unaligned target
        lat_min = 1; lat_max = 1;
        run(5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
        run(6);

        // back-to-back redirects, then PC wrap-around
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
        run(5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        run(8);

        // reset while the buffer is full, then restart from RESET_PC
        lat_min = 2; lat_max = 2;
        k_dec = 0;
        run(8);
        do_reset(1);
        k_dec = 100;
        run(8);

        // random traffic
        lat_min = 1; lat_max = 4;
        k_ready = 70; k_dec = 60; k_redir = 5;
        run(400);
        do_reset(1);
        lat_min = 1; lat_max = 2;
        k_ready = 90; k_dec = 90; k_redir = 10;
        run(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
